// File: rtl/iic_pkg.sv
// rtl/iic_pkg.sv - shared IIC bus constants and slave state encoding
package iic_pkg;

  localparam logic [7:0] DEVICE_WRADD = 8'hA2;
  localparam logic [7:0] DEVICE_RDADD = 8'hA3;
  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8
  } slv_state_e;

endpackage

// File: rtl/iic_slave_regs_if.sv
// rtl/iic_slave_regs_if.sv - register bus between the IIC slave and user register storage
interface iic_slave_regs_if;

  logic [7:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic [7:0] reg_rd_data;
  logic       busy;

  modport slave  (output reg_addr, reg_wr_en, reg_wr_data, busy, input reg_rd_data);
  modport master (input reg_addr, reg_wr_en, reg_wr_data, busy, output reg_rd_data);

endinterface

// File: rtl/iic_line_sync.sv
// rtl/iic_line_sync.sv - scl/sda synchronizers, edge and START/STOP detection
// IIC_GLITCH_FILTER_EN adds a FILT_LEN-sample agreement filter after the synchronizers.
module iic_line_sync
`ifdef IIC_GLITCH_FILTER_EN
#(
  parameter int FILT_LEN = 3
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_o,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_meta_q, scl_meta_d, sda_meta_q, sda_meta_d;
  logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic       scl_cur, sda_cur;

`ifdef IIC_GLITCH_FILTER_EN
  localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [CW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic          scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

  // Counter tracks how long the input has disagreed with the filtered value.
  always_comb begin
    scl_filt_d = scl_filt_q;
    scl_cnt_d  = '0;
    sda_filt_d = sda_filt_q;
    sda_cnt_d  = '0;
    if (scl_meta_q[1] != scl_filt_q) begin
      if (scl_cnt_q == CNT_LAST) scl_filt_d = scl_meta_q[1];
      else                       scl_cnt_d  = scl_cnt_q + 1'b1;
    end
    if (sda_meta_q[1] != sda_filt_q) begin
      if (sda_cnt_q == CNT_LAST) sda_filt_d = sda_meta_q[1];
      else                       sda_cnt_d  = sda_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
    end else begin
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
    end
  end

  assign scl_cur = scl_filt_q;
  assign sda_cur = sda_filt_q;
`else
  assign scl_cur = scl_meta_q[1];
  assign sda_cur = sda_meta_q[1];
`endif

  always_comb begin
    scl_meta_d = {scl_meta_q[0], scl_in};
    sda_meta_d = {sda_meta_q[0], sda_in};
    scl_prev_d = scl_cur;
    sda_prev_d = sda_cur;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_meta_q <= 2'b11;
      sda_meta_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_meta_d;
      sda_meta_q <= sda_meta_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign sda_o     = sda_cur;
  assign scl_rise  = scl_cur & ~scl_prev_q;
  assign scl_fall  = ~scl_cur & scl_prev_q;
  assign start_det = scl_cur & scl_prev_q & sda_prev_q & ~sda_cur;
  assign stop_det  = scl_cur & scl_prev_q & ~sda_prev_q & sda_cur;

endmodule

// File: rtl/iic_slave_regs.sv
// rtl/iic_slave_regs.sv - IIC slave exposing a register bus to user logic
// IIC_GLITCH_FILTER_EN enables the line glitch filter in iic_line_sync.
module iic_slave_regs
  import iic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h51
`ifdef IIC_GLITCH_FILTER_EN
  , parameter int FILT_LEN = 3
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            scl,
  inout  wire             sda,
  iic_slave_regs_if.slave bus
);

  logic sda_f, scl_rise, scl_fall, start_det, stop_det;

  iic_line_sync
`ifdef IIC_GLITCH_FILTER_EN
    #(.FILT_LEN(FILT_LEN))
`endif
  u_line_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl),
    .sda_in    (sda),
    .sda_o     (sda_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  slv_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, reg_addr_q, reg_addr_d, wr_data_q, wr_data_d;
  logic       sda_oe_q, sda_oe_d, wr_en_q, wr_en_d, busy_q, busy_d;
  logic       rw_q, rw_d, mack_q, mack_d;
  logic [7:0] rx_byte;
  logic       byte_done;

  // In the ACK states sda_oe_q doubles as the phase: low before the ACK is driven, high after.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    reg_addr_d = reg_addr_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    mack_d     = mack_q;
    rx_byte    = {shift_q[6:0], sda_f};
    byte_done  = scl_rise && (bit_cnt_q == 3'd0);

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd7;
      sda_oe_d  = 1'b0;
    end else begin
      if (scl_rise && (state_q inside {ST_ADDR, ST_PTR, ST_WDATA})) begin
        shift_d   = rx_byte;
        bit_cnt_d = bit_cnt_q - 3'd1;
      end
      case (state_q)
        ST_ADDR: if (byte_done) begin
          if (rx_byte[7:1] == DEV_ADDR) begin
            rw_d    = rx_byte[0];
            state_d = ST_ADDR_ACK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
          end else if (rw_q) begin
            shift_d   = bus.reg_rd_data;
            sda_oe_d  = ~bus.reg_rd_data[7];
            bit_cnt_d = 3'd7;
            state_d   = ST_RDATA;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
            state_d   = ST_PTR;
          end
        end
        ST_PTR: if (byte_done) state_d = ST_PTR_ACK;
        ST_PTR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d   = 1'b1;
            reg_addr_d = shift_q;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd7;
            state_d   = ST_WDATA;
          end
        end
        ST_WDATA: if (byte_done) begin
          wr_en_d   = 1'b1;
          wr_data_d = rx_byte;
          state_d   = ST_WDATA_ACK;
        end
        ST_WDATA_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d   = 1'b0;
            reg_addr_d = reg_addr_q + 8'd1;
            bit_cnt_d  = 3'd7;
            state_d    = ST_WDATA;
          end
        end
        ST_RDATA: if (scl_fall) begin
          if (bit_cnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
            mack_d   = 1'b0;
            state_d  = ST_RDATA_ACK;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oe_d  = ~shift_q[6];
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        ST_RDATA_ACK: begin
          // The pointer advances at the ACK rise so reg_rd_data has settled by the fall.
          if (scl_rise) begin
            if (sda_f == NACK) begin
              state_d = ST_IDLE;
            end else begin
              mack_d     = 1'b1;
              reg_addr_d = reg_addr_q + 8'd1;
            end
          end else if (scl_fall && mack_q) begin
            shift_d   = bus.reg_rd_data;
            sda_oe_d  = ~bus.reg_rd_data[7];
            bit_cnt_d = 3'd7;
            mack_d    = 1'b0;
            state_d   = ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd7;
      shift_q    <= 8'h00;
      sda_oe_q   <= 1'b0;
      reg_addr_q <= 8'h00;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      reg_addr_q <= reg_addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
    end
  end

  assign sda             = (sda_oe_q && rst_n) ? 1'b0 : 1'bz;
  assign bus.reg_addr    = reg_addr_q;
  assign bus.reg_wr_en   = wr_en_q;
  assign bus.reg_wr_data = wr_data_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_iic_slave_regs.sv
// tb/tb_iic_slave_regs.sv - bench acting as IIC master and user register storage for iic_slave_regs
module tb_iic_slave_regs;
  import iic_pkg::*;

  localparam int Q = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  wire  scl;
  wire  sda;
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0]  mem   [256] = '{default: 8'h00};
  logic [7:0]  model [256] = '{default: 8'h00};
  logic [15:0] wlog  [$];
  logic [7:0]  dq    [$];

  assign scl = m_scl;
  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  iic_slave_regs_if bus ();

  iic_slave_regs dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scl   (scl),
    .sda   (sda),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  assign bus.reg_rd_data = mem[bus.reg_addr];
  always @(posedge clk) if (bus.reg_wr_en) mem[bus.reg_addr] <= bus.reg_wr_data;
  always @(negedge clk) if (bus.reg_wr_en) wlog.push_back({bus.reg_addr, bus.reg_wr_data});

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic r);
    m_sda = b;    wclk(Q);
    m_scl = 1'b1; wclk(Q);
    r = sda;      wclk(Q);
    m_scl = 1'b0; wclk(Q);
  endtask

  task automatic start_c();
    m_sda = 1'b1; wclk(Q);
    m_scl = 1'b1; wclk(Q);
    m_sda = 1'b0; wclk(Q);
    m_scl = 1'b0; wclk(Q);
  endtask

  task automatic stop_c();
    m_sda = 1'b0; wclk(Q);
    m_scl = 1'b1; wclk(Q);
    m_sda = 1'b1; wclk(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(b[i], r);
    bit_x(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_x(1'b1, r);
      d = {d[6:0], r};
    end
    bit_x(mack, r);
  endtask

  task automatic do_write(input logic [7:0] ptr, input logic [7:0] d[$]);
    logic a;
    logic [7:0] p;
    p = ptr;
    wlog.delete();
    start_c();
    send_byte(DEVICE_WRADD, a);
    check("wr_dev_ack", 16'(a), 16'(ACK));
    check("wr_busy_in_frame", 16'(bus.busy), 16'd1);
    send_byte(ptr, a);
    check("wr_ptr_ack", 16'(a), 16'(ACK));
    foreach (d[i]) begin
      send_byte(d[i], a);
      check("wr_data_ack", 16'(a), 16'(ACK));
      model[p] = d[i];
      p = p + 8'd1;
    end
    stop_c();
    check("wr_pulse_count", 16'(wlog.size()), 16'(d.size()));
    for (int i = 0; i < d.size() && i < wlog.size(); i++)
      check("wr_addr_data", wlog[i], {8'(ptr + 8'(i)), d[i]});
    check("wr_busy_after_stop", 16'(bus.busy), 16'd0);
    check("wr_addr_end", 16'(bus.reg_addr), 16'(p));
  endtask

  task automatic do_read(input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] d;
    wlog.delete();
    start_c();
    send_byte(DEVICE_WRADD, a);
    check("rd_wdev_ack", 16'(a), 16'(ACK));
    send_byte(ptr, a);
    check("rd_ptr_ack", 16'(a), 16'(ACK));
    start_c();
    send_byte(DEVICE_RDADD, a);
    check("rd_rdev_ack", 16'(a), 16'(ACK));
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1) ? NACK : ACK, d);
      check("rd_data", 16'(d), 16'(model[8'(ptr + 8'(i))]));
    end
    check("rd_busy_hold_nack", 16'(bus.busy), 16'd1);
    check("rd_sda_released", 16'(sda), 16'd1);
    stop_c();
    check("rd_busy_after_stop", 16'(bus.busy), 16'd0);
    check("rd_addr_end", 16'(bus.reg_addr), 16'(8'(ptr + 8'(n - 1))));
    check("rd_no_write", 16'(wlog.size()), 16'd0);
  endtask

  initial begin
    logic a;
    logic r;
    logic [7:0] p;
    int n;

    wclk(5);
    rst_n = 1'b1;
    wclk(2);
    check("rst_reg_addr", 16'(bus.reg_addr), 16'h0000);
    check("rst_wr_en", 16'(bus.reg_wr_en), 16'd0);
    check("rst_wr_data", 16'(bus.reg_wr_data), 16'h0000);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_sda", 16'(sda), 16'd1);

    dq = {8'h5A};
    do_write(8'h10, dq);

    wlog.delete();
    start_c();
    send_byte(8'hA4, a);
    check("nack_other_dev", 16'(a), 16'(NACK));
    check("nack_busy", 16'(bus.busy), 16'd0);
    stop_c();
    check("nack_no_write", 16'(wlog.size()), 16'd0);

    dq = {8'h3C};
    do_write(8'h20, dq);
    do_read(8'h20, 1);

    dq = {8'h11, 8'h22, 8'h33};
    do_write(8'h20, dq);
    do_read(8'h20, 3);

    dq = {8'hAA, 8'hBB};
    do_write(8'hFF, dq);

    // Reset pulse during the 4th data bit of a write byte.
    wlog.delete();
    start_c();
    send_byte(DEVICE_WRADD, a);
    send_byte(8'h30, a);
    bit_x(1'b0, r);
    bit_x(1'b1, r);
    bit_x(1'b0, r);
    m_sda = 1'b1; wclk(Q);
    m_scl = 1'b1; wclk(Q / 2);
    rst_n = 1'b0; wclk(1);
    rst_n = 1'b1;
    check("midrst_busy", 16'(bus.busy), 16'd0);
    check("midrst_reg_addr", 16'(bus.reg_addr), 16'h0000);
    check("midrst_wr_en", 16'(bus.reg_wr_en), 16'd0);
    check("midrst_sda", 16'(sda), 16'd1);
    wclk(Q / 2);
    m_scl = 1'b0; wclk(Q);
    stop_c();
    check("midrst_no_write", 16'(wlog.size()), 16'd0);

    dq = {8'h77};
    do_write(8'h42, dq);

    for (int k = 0; k < 2; k++) begin
      p = 8'($urandom);
      n = int'($urandom_range(3, 1));
      dq = {};
      for (int j = 0; j < n; j++) dq.push_back(8'($urandom));
      do_write(p, dq);
      do_read(p, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iic_slave_regs.md
Name: iic_slave_regs

Overview:
- 8-bit IIC slave/responder; the far end of our IIC master controller.
- Answers write address 0xA2 and read address 0xA3 (7-bit 0x51) and runs the same frame formats: slave address + W, register pointer, then data bytes; or repeated start + slave address + R, then data bytes.
- Exposes a simple register-bus to user logic. User logic holds the register storage.
- Sits behind the board IIC pins (or the master's scl/sda in loopback benches), clocked from the 25 MHz system clock.

Parameters:
DEV_ADDR, 7'h51, 7-bit slave address (0xA2 = write, 0xA3 = read).
FILT_LEN, 3, number of consecutive equal samples required by the optional glitch filter.

Ports:
clk  input  1  system clock, 25 MHz.
rst_n  input  1  synchronous active-low reset.
scl  input  1  IIC clock from the master.
sda  inout  1  IIC data, open-drain style: driven 0 or released to 'z'; never driven 1.
reg_addr  output  8  register pointer presented to user logic.
reg_wr_en  output  1  one-cycle pulse; a data byte has been written.
reg_wr_data  output  8  written byte; valid while reg_wr_en is high.
reg_rd_data  input  8  user register contents at reg_addr; combinational; sampled 1 clk after reg_addr changes.
busy  output  1  high from an address-matched start until stop or NACK-exit.

Behaviour:
Reset values:
- reg_addr = 0, reg_wr_en = 0, reg_wr_data = 0, busy = 0.
- sda released; state IDLE.
- Synchronizer flops are set to 1.

Line handling:
- scl and sda pass through 2-FF synchronizers.
- Edge detection runs on the synchronized values: scl_rise and scl_fall.
- START = sda falling while scl high. STOP = sda rising while scl high.
- START or STOP in any state aborts the frame: release sda. STOP goes to IDLE; START goes to ADDR.
- START takes priority over the scl edge in the same cycle.

Data sampling and driving:
- Data is sampled on scl_rise, MSB first.
- The slave changes sda only on scl_fall, 1 clk after the edge is detected.

States:
IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.

- IDLE: wait for START, then go to ADDR (bit count 7).
- ADDR: shift 8 bits. After the 8th rise:
  - If bits[7:1] == DEV_ADDR: on the next scl_fall drive sda = 0 (ACK) and set busy = 1.
  - Otherwise go to IDLE, sda released (NACK); ignore everything until the next START.
- ADDR_ACK: on the scl_fall that ends the 9th clock:
  - R/W = 0: release sda, go to PTR.
  - R/W = 1: load the shift register from reg_rd_data, drive its MSB, go to RDATA.
- PTR: shift 8 bits, ACK as above, then load reg_addr with the byte. Go to PTR_ACK, then WDATA.
- WDATA: shift 8 bits. On the 8th rise:
  - reg_wr_data = byte, reg_wr_en = 1 for exactly one cycle, with the current reg_addr.
  - ACK, then reg_addr += 1 at the ACK-release fall (8-bit wrap, 0xFF to 0x00).
  - Go to WDATA_ACK, then back to WDATA.
- RDATA: drive bits on each scl_fall, sda = 0 or 'z'. After the 8th bit, release sda at the 8th fall.
- RDATA_ACK: sample the master bit on the 9th rise.
  - ACK (0): reg_addr += 1; at the 9th fall load the new reg_rd_data and drive its MSB; go to RDATA.
  - NACK (1): keep sda released, go to IDLE, busy = 0 at the following STOP.
- A repeated START after PTR_ACK keeps reg_addr, which is how random read works.

Other rules:
- reg_wr_en is never asserted for address or pointer bytes.
- busy clears on STOP, or on a NACK-exit once STOP arrives.
- Reset mid-frame: next clk everything returns to reset values, sda released immediately. A half-finished WDATA byte is never written.

Optional Feature:
- Macro IIC_GLITCH_FILTER_EN.
- When defined: after the synchronizers, each of scl and sda updates its filtered value only after FILT_LEN consecutive identical samples. This suppresses spikes shorter than FILT_LEN clk and adds FILT_LEN clk latency to every edge and START/STOP detection.
- When undefined: synchronized values are used directly and latency is 2 clk.
- Both variants must pass the full test plan with the master's 512-clk scl period.

Decomposition:
- Shared package iic_pkg holds:
  - The state encoding constants, 4-bit.
  - DEVICE_WRADD = 8'hA2 and DEVICE_RDADD = 8'hA3, shared with the master controller.
  - The ACK = 0 / NACK = 1 constants.
- Sub-module iic_line_sync: the synchronizers, the optional filter, and generation of scl_rise, scl_fall, start_det and stop_det. Instantiated once.

Test Plan:
- Write frame 0xA2, 0x10, 0x5A, STOP → ACK on all three 9th clocks; a single reg_wr_en pulse with reg_addr = 0x10 and reg_wr_data = 0x5A; busy falls after STOP.
- Address 0xA4 → sda stays released on the 9th clock (NACK); no reg_wr_en; busy stays 0; the following frame to 0xA2 is accepted.
- Random read 0xA2, 0x20, Sr, 0xA3 with reg_rd_data = 0x3C at 0x20, master NACK, STOP → master receives 0x3C; reg_addr stays 0x20; sda released.
- Sequential read from 0x20, master ACK, ACK, NACK, with data 0x11, 0x22, 0x33 → bytes received in order; reg_addr ends at 0x22.
- Burst write at pointer 0xFF: data 0xAA, 0xBB → writes to 0xFF then 0x00 (wrap); two reg_wr_en pulses.
- rst_n low for 1 clk during the 4th data bit of WDATA → no write pulse; sda released; a subsequent full frame is accepted normally.
